// File: rtl/audio_pkg.sv
// Shared constants and slot-bit helper for the I2S audio serializer.
// Slot positions count from the I2S delay bit (0), so the MSB sits at 1 and the LSB at 24.
package audio_pkg;

    localparam int SAMPLE_W     = 24;
    localparam int SLOT_BITS    = 32;
    localparam int FRAME_BITS   = 64;
    localparam int SLOT_POS_MSB = 1;
    localparam int SLOT_POS_LSB = 24;

    localparam int SLOT_CNT_W  = $clog2(SLOT_BITS);
    localparam int FRAME_CNT_W = $clog2(FRAME_BITS);

    // Serial data bit carried at a given slot position; outside the sample window the line is 0.
    function automatic logic slot_data(input logic [SAMPLE_W-1:0] word,
                                       input logic [SLOT_CNT_W-1:0] pos);
        logic [SLOT_CNT_W-1:0] idx;
        idx       = SLOT_CNT_W'(SAMPLE_W) - pos;
        slot_data = 1'b0;
        if (pos >= SLOT_CNT_W'(SLOT_POS_MSB) && pos <= SLOT_CNT_W'(SLOT_POS_LSB)) begin
            slot_data = word[idx];
        end
    endfunction

endpackage

// File: rtl/bclk_gen.sv
// Bit-clock divider: toggles bclk every BCLK_DIV clk cycles and flags the 1->0 toggle.
// fall_evt is high during the clk cycle whose closing edge produces the falling bclk transition.
module bclk_gen #(
    parameter int BCLK_DIV = 4
) (
    input  logic clk,
    input  logic resetn,
    output logic bclk,
    output logic fall_evt
);

    logic [7:0] div_cnt;
    logic       div_wrap;

    assign div_wrap = (div_cnt == 8'(BCLK_DIV - 1));
    assign fall_evt = div_wrap & bclk;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            div_cnt <= 8'd0;
            bclk    <= 1'b0;
        end else if (div_wrap) begin
            div_cnt <= 8'd0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/audio_serializer.sv
// Mono I2S master serializer: one 24-bit sample per 64-BCLK frame, duplicated to both slots.
// Every output is a flop; all frame state advances only on BCLK falling edges.
module audio_serializer
    import audio_pkg::*;
#(
    parameter int BCLK_DIV  = 4,
    parameter bit SIGNED_IN = 1'b0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                mute,
    output logic                aud_bclk,
    output logic                aud_daclrck,
    output logic                aud_dacdat,
    output logic                sample_strobe
);

    logic                   fall_evt;
    logic [FRAME_CNT_W-1:0] bit_cnt;
    logic [FRAME_CNT_W-1:0] bit_next;
    logic [SAMPLE_W-1:0]    shadow;
    logic [SAMPLE_W-1:0]    shadow_next;
    logic [SAMPLE_W-1:0]    sample_conv;
    logic                   frame_start;
    logic                   data_next;

    bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk      (clk),
        .resetn   (resetn),
        .bclk     (aud_bclk),
        .fall_evt (fall_evt)
    );

    // Offset-binary input becomes two's complement by flipping the sign bit.
    always_comb begin
        bit_next    = bit_cnt + FRAME_CNT_W'(1);
        frame_start = (bit_next == '0);
        sample_conv = SIGNED_IN ? sample
                                : {~sample[SAMPLE_W-1], sample[SAMPLE_W-2:0]};
        shadow_next = shadow;
        if (frame_start) begin
            shadow_next = mute ? '0 : sample_conv;
        end
        data_next   = slot_data(shadow_next, bit_next[SLOT_CNT_W-1:0]);
    end

    // bit_cnt resets to the last frame bit so the first fall after release begins frame bit 0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bit_cnt       <= '1;
            shadow        <= '0;
            aud_daclrck   <= 1'b0;
            aud_dacdat    <= 1'b0;
            sample_strobe <= 1'b0;
        end else begin
            sample_strobe <= fall_evt & frame_start;
            if (fall_evt) begin
                bit_cnt     <= bit_next;
                shadow      <= shadow_next;
                aud_daclrck <= bit_next[FRAME_CNT_W-1];
                aud_dacdat  <= data_next;
            end
        end
    end

endmodule

// File: doc/audio_serializer.md
AUDIO_SERIALIZER -- requirements
Module: audio_serializer

Interface
REQ-001 The block SHALL have parameter BCLK_DIV, default 4, giving the number of clk cycles per BCLK half-period; legal range is 1..255.
REQ-002 The block SHALL have parameter SIGNED_IN, default 0: 0 means sample is unsigned offset-binary and is converted by inverting bit 23; 1 means sample is two's complement and passes through unchanged.
REQ-003 clk  input  1  system clock; all logic is on posedge clk.
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 sample  input  24  mixed audio sample from the sound generator; sampled only at frame start.
REQ-006 mute  input  1  when high at frame start, the frame carries zero data.
REQ-007 aud_bclk  output  1  bit clock to the DAC (master mode).
REQ-008 aud_daclrck  output  1  word select: 0 = left slot, 1 = right slot.
REQ-009 aud_dacdat  output  1  serial data in I2S format, MSB first.
REQ-010 sample_strobe  output  1  one-clk pulse on the cycle the frame sample is latched.

Function
REQ-011 A divider counter SHALL count 0..BCLK_DIV-1 and toggle aud_bclk on the cycle it reaches BCLK_DIV-1, then wrap to 0.
REQ-012 A toggle taking aud_bclk 1->0 is a fall event; all data, word-select and strobe updates SHALL occur only on fall events.
REQ-013 A 6-bit bit counter SHALL increment on each fall event and wrap 63->0, giving a 64-BCLK frame of two 32-bit slots.
REQ-014 On the fall event where the bit counter becomes 0, the block SHALL latch the converted sample, or 24'h000000 if mute=1, into a shadow register and assert sample_strobe for exactly that clk cycle.
REQ-015 aud_daclrck SHALL be updated on each fall event to bit 5 of the new bit counter value.
REQ-016 Within each slot, at slot bit position p (bit counter mod 32), aud_dacdat SHALL be:
 - 0 when p = 0 (the I2S one-BCLK delay);
 - shadow[24-p] when p = 1..24;
 - 0 when p = 25..31.
REQ-017 The left and right slots SHALL carry the same shadow value (mono duplication).
REQ-018 Changes on sample or mute between frame starts SHALL have no effect on the frame in progress.
REQ-019 With BCLK_DIV=1, aud_bclk SHALL toggle every clk cycle, giving BCLK = clk/2.
REQ-020 The frame period SHALL be exactly 128*BCLK_DIV clk cycles with no drift or gaps.

Reset
REQ-021 While resetn=0 at posedge clk, the block SHALL set:
 - divider counter = 0, aud_bclk = 0, aud_daclrck = 0, aud_dacdat = 0;
 - sample_strobe = 0, shadow = 0;
 - bit counter = 63, so the first fall event after release starts frame bit 0.
REQ-022 Reset asserted mid-frame SHALL abort the frame, with all outputs at reset values on the next clk edge and no partial strobe afterwards.
REQ-023 After release, the first fall event SHALL occur 2*BCLK_DIV clk cycles after the first cycle with resetn=1.

Structure
REQ-024 The shared package audio_pkg SHALL hold SAMPLE_W=24, SLOT_BITS=32 and FRAME_BITS=64, together with the slot position constants for MSB (1) and LSB (24).
REQ-025 The divider SHALL be a separate sub-module bclk_gen with outputs bclk and a fall_evt pulse; bit sequencing and the shadow register SHALL stay in audio_serializer.
REQ-026 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Verification
REQ-027 Reset release, BCLK_DIV=4 -> sample_strobe first high 8 cycles after release, then every 512 cycles; aud_bclk period is 8 cycles.
REQ-028 SIGNED_IN=0, sample=24'h800001 -> each slot shifts 0, then 24'h000001 MSB-first, then seven 0s; left and right slots are identical.
REQ-029 SIGNED_IN=1, sample=24'hA5A5A5, then changed to 24'h000000 mid-frame -> the current frame still shows A5A5A5 and the next frame shows zeros.
REQ-030 mute=1 at frame start, sample=24'hFFFFFF -> aud_dacdat is 0 for all 64 bits and sample_strobe still pulses.
REQ-031 resetn pulsed low at bit 40 -> outputs return to reset values the next cycle and the first strobe after release follows REQ-023 timing.
REQ-032 BCLK_DIV=1 -> aud_bclk toggles every cycle and the frame lasts 128 cycles; aud_daclrck changes only on aud_bclk falling edges.
